// File: rtl/gaussian_5x5.sv
// 5x5 binomial Gaussian smoothing of one window: 25-entry register file feeding a
// shift-add weighted adder tree, normalized by 256. Define GAUSSIAN_ROUND_EN for round-half-up.
module gaussian_5x5 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pixel_in,
    input  logic [4:0]  pixel_id,
    output logic [15:0] pixel_out
);

    localparam int NUM_TAPS = 25;
    localparam int LEAVES   = 32;

`ifdef GAUSSIAN_ROUND_EN
    localparam logic [23:0] ROUND_BIAS = 24'd128;
`else
    localparam logic [23:0] ROUND_BIAS = 24'd0;
`endif

    // One row/column factor of the binomial kernel {1,4,6,4,1}.
    function automatic int binom(input int i);
        case (i)
            0, 4:    binom = 1;
            1, 3:    binom = 4;
            default: binom = 6;
        endcase
    endfunction

    // Constant multiply by a kernel weight as a shift-add; k is always an elaboration constant.
    function automatic logic [23:0] weigh(input logic [15:0] v, input int k);
        logic [23:0] x;
        x = {8'd0, v};
        case (k)
            1:       weigh = x;
            4:       weigh = x << 2;
            6:       weigh = (x << 2) + (x << 1);
            16:      weigh = x << 4;
            24:      weigh = (x << 4) + (x << 3);
            36:      weigh = (x << 5) + (x << 2);
            default: weigh = '0;
        endcase
    endfunction

    // Worst-case total is 65535*256 = 16,776,960, so 24 bits holds every partial sum.
    logic [23:0] lvl0 [LEAVES];
    logic [23:0] lvl1 [16];
    logic [23:0] lvl2 [8];
    logic [23:0] lvl3 [4];
    logic [23:0] lvl4 [2];
    logic [23:0] sum_next;
    logic [23:0] sum_round;
    logic [15:0] pixel_next;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            localparam int K = binom(gi / 5) * binom(gi % 5);
            logic [15:0] w_reg;

            // Ids 25..31 match no tap, so they are dropped without extra decode.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w_reg <= '0;
                end else if (pixel_id == 5'(gi)) begin
                    w_reg <= pixel_in;
                end
            end

            assign lvl0[gi] = weigh(w_reg, K);
        end

        for (gi = NUM_TAPS; gi < LEAVES; gi++) begin : g_pad
            assign lvl0[gi] = '0;
        end

        for (gi = 0; gi < 16; gi++) begin : g_lvl1
            assign lvl1[gi] = lvl0[2*gi] + lvl0[2*gi+1];
        end

        for (gi = 0; gi < 8; gi++) begin : g_lvl2
            assign lvl2[gi] = lvl1[2*gi] + lvl1[2*gi+1];
        end

        for (gi = 0; gi < 4; gi++) begin : g_lvl3
            assign lvl3[gi] = lvl2[2*gi] + lvl2[2*gi+1];
        end

        for (gi = 0; gi < 2; gi++) begin : g_lvl4
            assign lvl4[gi] = lvl3[2*gi] + lvl3[2*gi+1];
        end
    endgenerate

    assign sum_next = lvl4[0] + lvl4[1];

    // Max sum plus bias is 16,777,088, still below 2^24, so no carry is lost here.
    assign sum_round  = sum_next + ROUND_BIAS;
    assign pixel_next = 16'(sum_round >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= '0;
        end else begin
            pixel_out <= pixel_next;
        end
    end

endmodule

// File: tb/tb_gaussian_5x5.sv
// Directed self-checking bench for gaussian_5x5; expectations follow GAUSSIAN_ROUND_EN.
module tb_gaussian_5x5;

    logic        clk;
    logic        rst;
    logic [15:0] pixel_in;
    logic [4:0]  pixel_id;
    logic [15:0] pixel_out;

    int checks   = 0;
    int failures = 0;

`ifdef GAUSSIAN_ROUND_EN
    localparam logic [15:0] EXP_ID0_128 = 16'd1;
    localparam logic [15:0] EXP_MID     = 16'd215;
    localparam logic [15:0] EXP_MIX     = 16'd425;
`else
    localparam logic [15:0] EXP_ID0_128 = 16'd0;
    localparam logic [15:0] EXP_MID     = 16'd214;
    localparam logic [15:0] EXP_MIX     = 16'd424;
`endif

    // Hand-written kernel weights, row-major.
    logic [15:0] kern [25] = '{
        16'd1, 16'd4,  16'd6,  16'd4,  16'd1,
        16'd4, 16'd16, 16'd24, 16'd16, 16'd4,
        16'd6, 16'd24, 16'd36, 16'd24, 16'd6,
        16'd4, 16'd16, 16'd24, 16'd16, 16'd4,
        16'd1, 16'd4,  16'd6,  16'd4,  16'd1
    };

    gaussian_5x5 dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .pixel_id  (pixel_id),
        .pixel_out (pixel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge, well clear of the next one.
    task automatic write_px(input int id, input logic [15:0] v);
        pixel_id = 5'(id);
        pixel_in = v;
        @(posedge clk);
        #1;
        pixel_id = 5'd31;
    endtask

    task automatic idle(input int n);
        pixel_id = 5'd31;
        pixel_in = 16'd0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_all(input logic [15:0] v);
        for (int i = 0; i < 25; i++) write_px(i, v);
    endtask

    task automatic pulse_reset();
        pixel_id = 5'd31;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pixel_id = 5'd31;
        pixel_in = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pixel_out, 16'd0);
        rst = 1'b0;

        // Uniform window, then hold and out-of-range ids.
        write_all(16'd1000);
        idle(1);
        check("uniform_1000", pixel_out, 16'd1000);
        pixel_id = 5'd24;
        pixel_in = 16'd1000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_%0d", i), pixel_out, 16'd1000);
        end
        for (int id = 25; id < 32; id++) begin
            pixel_id = 5'(id);
            pixel_in = 16'd0;
            @(posedge clk);
            #1;
            check($sformatf("ignore_id%0d", id), pixel_out, 16'd1000);
        end
        idle(1);

        pulse_reset();
        write_all(16'd65535);
        idle(1);
        check("uniform_max", pixel_out, 16'd65535);

        // Write latency: output lags the register file by one edge.
        pulse_reset();
        write_px(12, 16'd256);
        check("latency_before", pixel_out, 16'd0);
        idle(1);
        check("impulse_centre", pixel_out, 16'd36);

        pulse_reset();
        write_px(0, 16'd128);
        idle(1);
        check("impulse_id0_128", pixel_out, EXP_ID0_128);

        // Per-position weight sweep; 256*k/256 is exact in both configs.
        for (int id = 0; id < 25; id++) begin
            pulse_reset();
            write_px(id, 16'd256);
            idle(1);
            check($sformatf("weight_id%0d", id), pixel_out, kern[id]);
        end

        // Back-to-back writes to different ids.
        pulse_reset();
        write_px(0, 16'd256);
        write_px(4, 16'd256);
        idle(1);
        check("back_to_back", pixel_out, 16'd2);

        // Mixed: 36*1000 + 1*65535 + 24*300 = 108735.
        pulse_reset();
        write_px(12, 16'd1000);
        write_px(0, 16'd65535);
        write_px(7, 16'd300);
        idle(1);
        check("mixed", pixel_out, EXP_MIX);

        // Partial window of ids 0..11 weighs 110 -> 55000.
        pulse_reset();
        for (int i = 0; i < 12; i++) write_px(i, 16'd500);
        idle(1);
        check("partial_0_11", pixel_out, EXP_MID);
        pixel_id = 5'd31;
        rst = 1'b1;
        #2;
        check("async_clear", pixel_out, 16'd0);
        rst = 1'b0;
        idle(1);
        check("after_reset_idle", pixel_out, 16'd0);
        write_px(12, 16'd100);
        idle(1);
        check("post_reset_id12", pixel_out, 16'd14);

        // Back-to-back windows separated by reset.
        pulse_reset();
        write_all(16'd200);
        idle(1);
        check("window_a", pixel_out, 16'd200);
        pulse_reset();
        write_all(16'd50);
        idle(1);
        check("window_b", pixel_out, 16'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
